// File: rtl/mul_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit.
// Produces a 2*WIDTH {hi,lo} result. Every output is registered from the current state.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             op_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             dbz_q;
    logic [WIDTH:0]   m_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q;
    logic             qm1_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dbz_out_q;

    logic             a_neg_d;
    logic             b_neg_d;
    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;
    logic [WIDTH:0]   booth_sum_d;
    logic [WIDTH:0]   shl_d;
    logic [WIDTH:0]   trial_d;
    logic [WIDTH:0]   acc_d;
    logic [WIDTH-1:0] q_d;
    logic             qm1_d;
    logic [WIDTH-1:0] hi_fix_d;
    logic [WIDTH-1:0] lo_fix_d;

    // Operand magnitudes; -(2^(W-1)) wraps onto itself and is read as unsigned 2^(W-1).
    always_comb begin
        a_neg_d = operand_A[WIDTH-1];
        b_neg_d = operand_B[WIDTH-1];
        if (a_neg_d) begin
            a_mag_d = -operand_A;
        end else begin
            a_mag_d = operand_A;
        end
        if (b_neg_d) begin
            b_mag_d = -operand_B;
        end else begin
            b_mag_d = operand_B;
        end
    end

    // One iteration: Booth add/sub plus arithmetic shift, or one restoring-divide step.
    always_comb begin
        booth_sum_d = acc_q;
        acc_d       = acc_q;
        q_d         = q_q;
        qm1_d       = qm1_q;
        shl_d       = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial_d     = shl_d - m_q;
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum_d = acc_q + m_q;
            2'b10:   booth_sum_d = acc_q - m_q;
            default: booth_sum_d = acc_q;
        endcase
        if (op_q) begin
            if (!trial_d[WIDTH]) begin
                acc_d = trial_d;
                q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shl_d;
                q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = {booth_sum_d[WIDTH], booth_sum_d[WIDTH:1]};
            q_d   = {booth_sum_d[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
        end
    end

    // Divide sign correction: quotient by sign(A)^sign(B), remainder follows A.
    always_comb begin
        if (qneg_q) begin
            lo_fix_d = -q_q;
        end else begin
            lo_fix_d = q_q;
        end
        if (rneg_q) begin
            hi_fix_d = -acc_q[WIDTH-1:0];
        end else begin
            hi_fix_d = acc_q[WIDTH-1:0];
        end
    end

    // Control FSM, working registers and registered outputs.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dbz_q     <= 1'b0;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            busy_q <= (state_q == S_CALC) || (state_q == S_SIGN);
            done_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                hi_q      <= acc_q[WIDTH-1:0];
                lo_q      <= q_q;
                dbz_out_q <= dbz_q;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q  <= op_div;
                        cnt_q <= '0;
                        qm1_q <= 1'b0;
                        acc_q <= '0;
                        if (op_div && (operand_B == '0)) begin
                            q_q     <= '0;
                            dbz_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            dbz_q   <= 1'b0;
                            state_q <= S_CALC;
                            qneg_q  <= a_neg_d ^ b_neg_d;
                            rneg_q  <= a_neg_d;
                            if (op_div) begin
                                m_q <= {1'b0, b_mag_d};
                                q_q <= a_mag_d;
                            end else begin
                                m_q <= {operand_A[WIDTH-1], operand_A};
                                q_q <= operand_B;
                            end
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= S_SIGN;
                    end else begin
                        state_q <= S_CALC;
                    end
                end
                S_SIGN: begin
                    if (op_q) begin
                        acc_q <= {1'b0, hi_fix_d};
                        q_q   <= lo_fix_d;
                    end else begin
                        acc_q <= acc_q;
                    end
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed products, quotients, latencies and reset behaviour.
module tb_mul_div_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic [31:0] operand_A = 32'h0;
    logic [31:0] operand_B = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;
    int lat = 0;
    int busy_cnt = 0;
    int seen = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .op_div     (op_div),
        .operand_A  (operand_A),
        .operand_B  (operand_B),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one start cycle, then scrambles the operands to prove they were latched.
    task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start     = 1'b1;
        op_div    = op;
        operand_A = a;
        operand_B = b;
        @(negedge clock);
        start     = 1'b0;
        op_div    = ~op;
        operand_A = 32'h5A5A_1234;
        operand_B = 32'h0000_0003;
    endtask

    // Counts cycles after the start edge until done; optionally re-pulses start at cycle 'repulse'.
    task automatic wait_done(input int repulse);
        lat = 0;
        busy_cnt = 0;
        do begin
            if (lat == repulse) begin
                start     = 1'b1;
                op_div    = 1'b1;
                operand_A = 32'h1;
                operand_B = 32'h1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            lat++;
            if (busy === 1'b1) busy_cnt++;
        end while (done !== 1'b1 && lat < 200);
        start = 1'b0;
        chk("done_seen", {63'h0, done}, 64'h1);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_hi", {32'h0, hi}, 64'h0);
        chk("rst_lo", {32'h0, lo}, 64'h0);
        chk("rst_flags", {61'h0, busy, done, div_by_zero}, 64'h0);
        clear = 1'b1;

        launch(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done(-1);
        chk("mul1_lat", 64'(lat), 64'd34);
        chk("mul1_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul1_dbz", {63'h0, div_by_zero}, 64'h0);
        @(negedge clock);
        chk("done_pulse", {63'h0, done}, 64'h0);

        launch(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(-1);
        chk("mul2_res", {hi, lo}, 64'h4000_0000_0000_0000);
        chk("mul2_busycnt", 64'(busy_cnt), 64'd33);
        chk("mul2_busy_at_done", {63'h0, busy}, 64'h0);

        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(-1);
        chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        launch(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(-1);
        chk("div_7_m2", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        launch(1'b1, 32'd5, 32'd0);
        wait_done(-1);
        chk("dbz_lat", 64'(lat), 64'd1);
        chk("dbz_flag", {63'h0, div_by_zero}, 64'h1);
        chk("dbz_res", {hi, lo}, 64'h0);

        launch(1'b1, 32'd100, 32'd7);
        chk("hold_dbz", {63'h0, div_by_zero}, 64'h1);
        wait_done(-1);
        chk("div100_lat", 64'(lat), 64'd34);
        chk("div100_res", {hi, lo}, 64'h0000_0002_0000_000E);
        chk("div100_dbz", {63'h0, div_by_zero}, 64'h0);

        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("hold_lo", {32'h0, lo}, 64'd14);
        wait_done(5);
        chk("min_div_lat", 64'(lat), 64'd34);
        chk("min_div_res", {hi, lo}, 64'h0000_0000_8000_0000);
        chk("min_div_dbz", {63'h0, div_by_zero}, 64'h0);

        launch(1'b0, 32'd3, 32'd4);
        repeat (10) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        chk("clr_res", {hi, lo}, 64'h0);
        chk("clr_flags", {61'h0, busy, done, div_by_zero}, 64'h0);
        clear = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) seen++;
        end
        chk("clr_no_done", 64'(seen), 64'd0);

        launch(1'b0, 32'd3, 32'd4);
        repeat (33) @(negedge clock);
        start     = 1'b1;
        op_div    = 1'b0;
        operand_A = 32'd5;
        operand_B = 32'd6;
        @(negedge clock);
        start = 1'b0;
        chk("b2b_done1", {63'h0, done}, 64'h1);
        chk("b2b_res1", {hi, lo}, 64'd12);
        wait_done(-1);
        chk("b2b_lat2", 64'(lat), 64'd34);
        chk("b2b_res2", {hi, lo}, 64'd30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
